// File: rtl/hier_icache_ctrl_seq.sv
// Register-mapped sequencer for hierarchical icache maintenance: turns peripheral
// writes into per-target req/ack handshakes towards the L1 caches and the L2 banks.
module hier_icache_ctrl_seq #(
    parameter int   NB_CACHE_BANKS = 4,
    parameter int   NB_CORES       = 9,
    parameter int   ID_WIDTH       = 5,
    parameter int   TIMEOUT_CYCLES = 1024,
    parameter logic ENABLE_RST     = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      speriph_slave_req_i,
    input  logic [31:0]               speriph_slave_addr_i,
    input  logic                      speriph_slave_wen_i,
    input  logic [31:0]               speriph_slave_wdata_i,
    input  logic [3:0]                speriph_slave_be_i,
    input  logic [ID_WIDTH-1:0]       speriph_slave_id_i,
    output logic                      speriph_slave_gnt_o,
    output logic                      speriph_slave_r_valid_o,
    output logic                      speriph_slave_r_opc_o,
    output logic [ID_WIDTH-1:0]       speriph_slave_r_id_o,
    output logic [31:0]               speriph_slave_r_rdata_o,
    output logic [NB_CORES-1:0]       l1_flush_req_o,
    input  logic [NB_CORES-1:0]       l1_flush_ack_i,
    output logic [NB_CORES-1:0]       l1_sel_flush_req_o,
    input  logic [NB_CORES-1:0]       l1_sel_flush_ack_i,
    output logic [NB_CACHE_BANKS-1:0] l2_enable_req_o,
    input  logic [NB_CACHE_BANKS-1:0] l2_enable_ack_i,
    output logic [NB_CACHE_BANKS-1:0] l2_disable_req_o,
    input  logic [NB_CACHE_BANKS-1:0] l2_disable_ack_i,
    output logic [NB_CACHE_BANKS-1:0] l2_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0] l2_flush_ack_i,
    output logic [NB_CACHE_BANKS-1:0] l2_sel_flush_req_o,
    input  logic [NB_CACHE_BANKS-1:0] l2_sel_flush_ack_i,
    output logic [31:0]               sel_flush_addr_o,
    output logic [NB_CORES-1:0]       enable_l1_l15_prefetch_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic WDOG_ON = (TIMEOUT_CYCLES > 0);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic [2:0] {CMD_EN, CMD_DIS, CMD_L2_FLUSH, CMD_L1_FLUSH, CMD_SEL_FLUSH} cmd_t;

    state_t                    state;
    cmd_t                      cmd;
    logic [NB_CORES-1:0]       pend_l1;
    logic [NB_CACHE_BANKS-1:0] pend_l2;
    logic [CNT_W-1:0]          cnt;
    logic                      en;
    logic                      err;

    logic [2:0]                idx;
    logic                      wr;
    logic                      busy;
    logic                      cmd_start;
    logic                      unmapped;
    logic [31:0]               rdata_mux;
    logic [NB_CORES-1:0]       l1_ack;
    logic [NB_CACHE_BANKS-1:0] l2_ack;
    logic [NB_CORES-1:0]       pend_l1_nxt;
    logic [NB_CACHE_BANKS-1:0] pend_l2_nxt;
    logic                      all_done;
    logic                      timeout_hit;
    logic                      unused_bits;

    assign idx       = speriph_slave_addr_i[4:2];
    assign wr        = speriph_slave_req_i & ~speriph_slave_wen_i;
    assign busy      = (state == ST_WAIT);
    assign unmapped  = idx[2] & idx[1];
    assign speriph_slave_gnt_o = speriph_slave_req_i & ~(busy & wr & ~idx[2]);
    assign cmd_start = speriph_slave_gnt_o & wr & ~idx[2];
    assign unused_bits = ^{speriph_slave_be_i, speriph_slave_addr_i[31:5], speriph_slave_addr_i[1:0]};

    // Only the ack lines of the command in flight can retire pending targets.
    always_comb begin
        l1_ack = '0;
        l2_ack = '0;
        case (cmd)
            CMD_EN:        l2_ack = l2_enable_ack_i;
            CMD_DIS:       l2_ack = l2_disable_ack_i;
            CMD_L2_FLUSH:  l2_ack = l2_flush_ack_i;
            CMD_L1_FLUSH:  l1_ack = l1_flush_ack_i;
            CMD_SEL_FLUSH: begin
                l1_ack = l1_sel_flush_ack_i;
                l2_ack = l2_sel_flush_ack_i;
            end
            default: ;
        endcase
    end

    assign pend_l1_nxt = pend_l1 & ~l1_ack;
    assign pend_l2_nxt = pend_l2 & ~l2_ack;
    assign all_done    = ~|{pend_l1_nxt, pend_l2_nxt};
    assign timeout_hit = WDOG_ON && (cnt == CNT_LAST);

    always_comb begin
        rdata_mux = '0;
        case (idx)
            3'd0: rdata_mux[0] = en;
            3'd3: rdata_mux = sel_flush_addr_o;
            3'd4: rdata_mux[NB_CORES-1:0] = enable_l1_l15_prefetch_o;
            3'd5: rdata_mux[2:0] = {en, err, busy};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                    <= ST_IDLE;
            cmd                      <= CMD_EN;
            pend_l1                  <= '0;
            pend_l2                  <= '0;
            cnt                      <= '0;
            en                       <= ENABLE_RST;
            err                      <= 1'b0;
            l1_flush_req_o           <= '0;
            l1_sel_flush_req_o       <= '0;
            l2_enable_req_o          <= '0;
            l2_disable_req_o         <= '0;
            l2_flush_req_o           <= '0;
            l2_sel_flush_req_o       <= '0;
            sel_flush_addr_o         <= '0;
            enable_l1_l15_prefetch_o <= '0;
            speriph_slave_r_valid_o  <= 1'b0;
            speriph_slave_r_opc_o    <= 1'b0;
            speriph_slave_r_id_o     <= '0;
            speriph_slave_r_rdata_o  <= '0;
        end else begin
            speriph_slave_r_valid_o <= speriph_slave_gnt_o;
            if (speriph_slave_gnt_o) begin
                speriph_slave_r_id_o    <= speriph_slave_id_i;
                speriph_slave_r_opc_o   <= unmapped;
                speriph_slave_r_rdata_o <= speriph_slave_wen_i ? rdata_mux : '0;
            end
            if (speriph_slave_gnt_o && wr && idx == 3'd4)
                enable_l1_l15_prefetch_o <= speriph_slave_wdata_i[NB_CORES-1:0];
            if (speriph_slave_gnt_o && wr && idx == 3'd5 && speriph_slave_wdata_i[1])
                err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (cmd_start) begin
                        case (idx[1:0])
                            2'd0: begin
                                cmd     <= speriph_slave_wdata_i[0] ? CMD_EN : CMD_DIS;
                                pend_l2 <= '1;
                                if (speriph_slave_wdata_i[0]) l2_enable_req_o  <= '1;
                                else                          l2_disable_req_o <= '1;
                                state   <= ST_WAIT;
                            end
                            2'd1: begin
                                cmd            <= CMD_L2_FLUSH;
                                pend_l2        <= '1;
                                l2_flush_req_o <= '1;
                                state          <= ST_WAIT;
                            end
                            2'd2: begin
                                // An empty core mask has nothing to wait for.
                                if (|speriph_slave_wdata_i[NB_CORES-1:0]) begin
                                    cmd            <= CMD_L1_FLUSH;
                                    pend_l1        <= speriph_slave_wdata_i[NB_CORES-1:0];
                                    l1_flush_req_o <= speriph_slave_wdata_i[NB_CORES-1:0];
                                    state          <= ST_WAIT;
                                end
                            end
                            default: begin
                                cmd                <= CMD_SEL_FLUSH;
                                pend_l1            <= '1;
                                pend_l2            <= '1;
                                l1_sel_flush_req_o <= '1;
                                l2_sel_flush_req_o <= '1;
                                sel_flush_addr_o   <= speriph_slave_wdata_i;
                                state              <= ST_WAIT;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    // A completing ack takes priority over the watchdog on the same cycle.
                    if (all_done || timeout_hit) begin
                        state              <= ST_IDLE;
                        pend_l1            <= '0;
                        pend_l2            <= '0;
                        l1_flush_req_o     <= '0;
                        l1_sel_flush_req_o <= '0;
                        l2_enable_req_o    <= '0;
                        l2_disable_req_o   <= '0;
                        l2_flush_req_o     <= '0;
                        l2_sel_flush_req_o <= '0;
                        if (all_done) begin
                            if (cmd == CMD_EN)  en <= 1'b1;
                            if (cmd == CMD_DIS) en <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt                <= cnt + 1'b1;
                        pend_l1            <= pend_l1_nxt;
                        pend_l2            <= pend_l2_nxt;
                        l1_flush_req_o     <= l1_flush_req_o & ~l1_flush_ack_i;
                        l1_sel_flush_req_o <= l1_sel_flush_req_o & ~l1_sel_flush_ack_i;
                        l2_enable_req_o    <= l2_enable_req_o & ~l2_enable_ack_i;
                        l2_disable_req_o   <= l2_disable_req_o & ~l2_disable_ack_i;
                        l2_flush_req_o     <= l2_flush_req_o & ~l2_flush_ack_i;
                        l2_sel_flush_req_o <= l2_sel_flush_req_o & ~l2_sel_flush_ack_i;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_icache_ctrl_seq.sv
// Directed bench for hier_icache_ctrl_seq with a shortened watchdog (8 cycles);
// every expected value below is worked out by hand from the register map.
module tb_hier_icache_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [4:0]  r_id;
    logic [31:0] r_rdata;
    logic [8:0]  l1_flush_req, l1_flush_ack;
    logic [8:0]  l1_sel_flush_req, l1_sel_flush_ack;
    logic [3:0]  l2_enable_req, l2_enable_ack;
    logic [3:0]  l2_disable_req, l2_disable_ack;
    logic [3:0]  l2_flush_req, l2_flush_ack;
    logic [3:0]  l2_sel_flush_req, l2_sel_flush_ack;
    logic [31:0] sel_flush_addr;
    logic [8:0]  prefetch;

    int   total;
    int   bad;
    logic gnt_seen;

    hier_icache_ctrl_seq #(
        .NB_CACHE_BANKS(4),
        .NB_CORES(9),
        .ID_WIDTH(5),
        .TIMEOUT_CYCLES(8),
        .ENABLE_RST(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .speriph_slave_req_i(req),
        .speriph_slave_addr_i(addr),
        .speriph_slave_wen_i(wen),
        .speriph_slave_wdata_i(wdata),
        .speriph_slave_be_i(be),
        .speriph_slave_id_i(id),
        .speriph_slave_gnt_o(gnt),
        .speriph_slave_r_valid_o(r_valid),
        .speriph_slave_r_opc_o(r_opc),
        .speriph_slave_r_id_o(r_id),
        .speriph_slave_r_rdata_o(r_rdata),
        .l1_flush_req_o(l1_flush_req),
        .l1_flush_ack_i(l1_flush_ack),
        .l1_sel_flush_req_o(l1_sel_flush_req),
        .l1_sel_flush_ack_i(l1_sel_flush_ack),
        .l2_enable_req_o(l2_enable_req),
        .l2_enable_ack_i(l2_enable_ack),
        .l2_disable_req_o(l2_disable_req),
        .l2_disable_ack_i(l2_disable_ack),
        .l2_flush_req_o(l2_flush_req),
        .l2_flush_ack_i(l2_flush_ack),
        .l2_sel_flush_req_o(l2_sel_flush_req),
        .l2_sel_flush_ack_i(l2_sel_flush_ack),
        .sel_flush_addr_o(sel_flush_addr),
        .enable_l1_l15_prefetch_o(prefetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus beat; returns just after the edge that registers the response.
    task automatic applyStimulus(input logic [2:0] idx_v, input logic wen_v,
                                 input logic [31:0] wdata_v, input logic [4:0] id_v);
        req   = 1'b1;
        addr  = 32'h1B20_0000 | {27'b0, idx_v, 2'b00};
        wen   = wen_v;
        wdata = wdata_v;
        id    = id_v;
        #1 gnt_seen = gnt;
        @(posedge clk);
        #1;
        req   = 1'b0;
        wen   = 1'b1;
        wdata = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = '0;
        wen   = 1'b1;
        wdata = '0;
        be    = 4'hF;
        id    = '0;
        l1_flush_ack = '0; l1_sel_flush_ack = '0;
        l2_enable_ack = '0; l2_disable_ack = '0; l2_flush_ack = '0; l2_sel_flush_ack = '0;
        $display("[TB] start");

        tick(); tick();
        checkOutput("rst_l1_reqs", {14'b0, l1_flush_req, l1_sel_flush_req}, 32'h0);
        checkOutput("rst_l2_reqs", {16'b0, l2_enable_req, l2_disable_req, l2_flush_req, l2_sel_flush_req}, 32'h0);
        checkOutput("rst_prefetch", {23'b0, prefetch}, 32'h0);
        checkOutput("rst_rvalid", {31'b0, r_valid}, 32'h0);
        checkOutput("rst_sel_addr", sel_flush_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        applyStimulus(3'd5, 1'b1, 32'h0, 5'h05);
        checkOutput("status_rst_gnt", {31'b0, gnt_seen}, 32'h1);
        checkOutput("status_rst_rvalid", {31'b0, r_valid}, 32'h1);
        checkOutput("status_rst_rid", {27'b0, r_id}, 32'h05);
        checkOutput("status_rst", r_rdata, 32'h4);

        // L1 flush of cores 0 and 2, acked one at a time; stray acks ignored.
        applyStimulus(3'd2, 1'b0, 32'h005, 5'h02);
        checkOutput("l1f_gnt", {31'b0, gnt_seen}, 32'h1);
        checkOutput("l1f_req0", {23'b0, l1_flush_req}, 32'h005);
        tick();
        checkOutput("l1f_req1", {23'b0, l1_flush_req}, 32'h005);
        l1_flush_ack = 9'h003;
        l2_flush_ack = 4'hF;
        tick();
        l1_flush_ack = '0;
        l2_flush_ack = '0;
        checkOutput("l1f_req2", {23'b0, l1_flush_req}, 32'h004);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h03);
        checkOutput("l1f_status_busy", r_rdata, 32'h5);
        tick();
        l1_flush_ack = 9'h004;
        tick();
        l1_flush_ack = '0;
        checkOutput("l1f_req_done", {23'b0, l1_flush_req}, 32'h000);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h04);
        checkOutput("l1f_status_idle", r_rdata, 32'h4);

        // Prefetch mask is a plain RW register.
        applyStimulus(3'd4, 1'b0, 32'hFFFF_F1A5, 5'h06);
        checkOutput("pf_out", {23'b0, prefetch}, 32'h1A5);
        applyStimulus(3'd4, 1'b1, 32'h0, 5'h06);
        checkOutput("pf_read", r_rdata, 32'h1A5);

        // Empty core mask: no request, never busy.
        applyStimulus(3'd2, 1'b0, 32'h0000_FE00, 5'h07);
        checkOutput("l1f_empty_req", {23'b0, l1_flush_req}, 32'h000);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h07);
        checkOutput("l1f_empty_status", r_rdata, 32'h4);

        // L2 flush in flight back-pressures command writes but not reads.
        applyStimulus(3'd1, 1'b0, 32'h0, 5'h07);
        checkOutput("l2f_req", {28'b0, l2_flush_req}, 32'hF);
        applyStimulus(3'd0, 1'b0, 32'h0, 5'h08);
        checkOutput("busy_en_gnt", {31'b0, gnt_seen}, 32'h0);
        checkOutput("busy_en_rvalid", {31'b0, r_valid}, 32'h0);
        checkOutput("busy_dis_req", {28'b0, l2_disable_req}, 32'h0);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h09);
        checkOutput("busy_read_gnt", {31'b0, gnt_seen}, 32'h1);
        checkOutput("busy_read_rid", {27'b0, r_id}, 32'h09);
        checkOutput("busy_status", r_rdata, 32'h5);
        l2_flush_ack = 4'hF;
        tick();
        l2_flush_ack = '0;
        checkOutput("l2f_done", {28'b0, l2_flush_req}, 32'h0);

        applyStimulus(3'd0, 1'b0, 32'h0, 5'h0A);
        checkOutput("dis_gnt", {31'b0, gnt_seen}, 32'h1);
        checkOutput("dis_req", {24'b0, l2_enable_req, l2_disable_req}, 32'h0F);
        l2_disable_ack = 4'h3;
        tick();
        l2_disable_ack = '0;
        checkOutput("dis_req_part", {28'b0, l2_disable_req}, 32'hC);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h0B);
        checkOutput("dis_status_wait", r_rdata, 32'h5);
        l2_disable_ack = 4'hC;
        tick();
        l2_disable_ack = '0;
        checkOutput("dis_req_done", {28'b0, l2_disable_req}, 32'h0);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h0C);
        checkOutput("dis_status", r_rdata, 32'h0);
        applyStimulus(3'd0, 1'b1, 32'h0, 5'h0C);
        checkOutput("dis_en_read", r_rdata, 32'h0);

        applyStimulus(3'd0, 1'b0, 32'h1, 5'h0D);
        checkOutput("en_req", {24'b0, l2_enable_req, l2_disable_req}, 32'hF0);
        l2_enable_ack = 4'hF;
        tick();
        l2_enable_ack = '0;
        checkOutput("en_req_done", {28'b0, l2_enable_req}, 32'h0);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h0D);
        checkOutput("en_status", r_rdata, 32'h4);

        // Selective flush hits every core and every bank with one shared address.
        applyStimulus(3'd3, 1'b0, 32'h1C00_0040, 5'h0E);
        checkOutput("sel_addr", sel_flush_addr, 32'h1C00_0040);
        checkOutput("sel_l1_req", {23'b0, l1_sel_flush_req}, 32'h1FF);
        checkOutput("sel_l2_req", {28'b0, l2_sel_flush_req}, 32'hF);
        l2_sel_flush_ack = 4'hF;
        tick();
        l2_sel_flush_ack = '0;
        checkOutput("sel_l2_done", {28'b0, l2_sel_flush_req}, 32'h0);
        checkOutput("sel_l1_hold", {23'b0, l1_sel_flush_req}, 32'h1FF);
        l1_sel_flush_ack = 9'h1FF;
        tick();
        l1_sel_flush_ack = '0;
        checkOutput("sel_l1_done", {23'b0, l1_sel_flush_req}, 32'h0);
        applyStimulus(3'd3, 1'b1, 32'h0, 5'h0F);
        checkOutput("sel_addr_read", r_rdata, 32'h1C00_0040);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h0F);
        checkOutput("sel_status", r_rdata, 32'h4);

        // Reset while waiting drops requests immediately.
        applyStimulus(3'd1, 1'b0, 32'h0, 5'h10);
        checkOutput("mid_rst_req_before", {28'b0, l2_flush_req}, 32'hF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req_after", {28'b0, l2_flush_req}, 32'h0);
        checkOutput("mid_rst_prefetch", {23'b0, prefetch}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h11);
        checkOutput("mid_rst_status", r_rdata, 32'h4);

        // Bank 3 never acks: watchdog aborts at the end of the 8th WAIT cycle.
        applyStimulus(3'd1, 1'b0, 32'h0, 5'h12);
        checkOutput("wd_req0", {28'b0, l2_flush_req}, 32'hF);
        l2_flush_ack = 4'h7;
        tick();
        l2_flush_ack = '0;
        checkOutput("wd_req1", {28'b0, l2_flush_req}, 32'h8);
        repeat (6) tick();
        checkOutput("wd_req7", {28'b0, l2_flush_req}, 32'h8);
        tick();
        checkOutput("wd_req8", {28'b0, l2_flush_req}, 32'h0);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h13);
        checkOutput("wd_status", r_rdata, 32'h6);
        applyStimulus(3'd5, 1'b0, 32'h2, 5'h14);
        applyStimulus(3'd5, 1'b1, 32'h0, 5'h15);
        checkOutput("wd_status_w1c", r_rdata, 32'h4);

        // Unmapped read returns an error response with the request id.
        applyStimulus(3'd7, 1'b1, 32'h0, 5'h1A);
        checkOutput("unm_gnt", {31'b0, gnt_seen}, 32'h1);
        checkOutput("unm_rvalid", {31'b0, r_valid}, 32'h1);
        checkOutput("unm_opc", {31'b0, r_opc}, 32'h1);
        checkOutput("unm_rid", {27'b0, r_id}, 32'h1A);
        checkOutput("unm_rdata", r_rdata, 32'h0);
        tick();
        checkOutput("unm_rvalid_drop", {31'b0, r_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
